ntt_unified_butterfly: RTL

//  Pipelined radix-2 butterfly serving both NTT directions: Cooley-Tukey (forward) and Gentleman-Sande (inverse).

---
 rtl/ntt_unified_butterfly.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/ntt_unified_butterfly.sv
// ntt_unified_butterfly
//   Pipelined radix-2 butterfly for both NTT directions.
//     mode=0 Cooley-Tukey : outa = a + b*rou,      outb = a - b*rou        (mod q)
//     mode=1 Gentleman-Sande: outa = H(a + b),    outb = H((a - b)*rou)   (mod q)
//   H() halves mod q when half_en=1 in GS mode, otherwise passes through.
//   One beat per cycle, latency MULT_LAT+3 for both modes; valid/tag/mode ride
//   alongside the data, so CT and GS beats may be mixed back to back.
// Ports
//   clk, rstn                 clock (rising edge), asynchronous active-low reset
//   in_valid, mode, half_en   beat qualifier and per-beat controls
//   a, b, rou, in_tag         operands (< q) and opaque pass-through tag
//   q, m, k2                  modulus, Barrett constant, Barrett shift (quasi-static)
//   out_valid, outa, outb     result beat
//   out_tag                   in_tag of the result beat
//   busy                      any beat still in flight
`ifndef BIT_WIDTH
`define BIT_WIDTH 24
`endif
module ntt_unified_butterfly #(
  parameter int BIT_WIDTH = `BIT_WIDTH,
  parameter int MULT_LAT  = 9,
  parameter int TAG_W     = 12
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic                 mode,
  input  logic                 half_en,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic [BIT_WIDTH-1:0] rou,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [BIT_WIDTH-1:0] q,
  input  logic [BIT_WIDTH:0]   m,
  input  logic [6:0]           k2,
  output logic                 out_valid,
  output logic [BIT_WIDTH-1:0] outa,
  output logic [BIT_WIDTH-1:0] outb,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);
  localparam int BW  = BIT_WIDTH;
  localparam int ML  = MULT_LAT;   // the reduction below needs ML >= 2
  localparam int CMW = 3 * BW + 1; // width of product * m

  function automatic logic [BW-1:0] add_mod(input logic [BW-1:0] x, input logic [BW-1:0] y,
                                            input logic [BW-1:0] md);
    logic [BW:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, md}) s = s - {1'b0, md};
    return BW'(s);
  endfunction

  function automatic logic [BW-1:0] sub_mod(input logic [BW-1:0] x, input logic [BW-1:0] y,
                                            input logic [BW-1:0] md);
    logic [BW:0] s;
    s = {1'b0, x} - {1'b0, y};
    if (x < y) s = s + {1'b0, md};
    return BW'(s);
  endfunction

  // x/2 mod q: odd values borrow one q first so the shift is exact
  function automatic logic [BW-1:0] halve(input logic [BW-1:0] x, input logic [BW-1:0] md);
    logic [BW:0] t;
    t = x[0] ? ({1'b0, x} + {1'b0, md}) : {1'b0, x};
    return BW'(t >> 1);
  endfunction

  // Stage 1: input register
  logic [BW-1:0]    a_s1_q, b_s1_q, rou_s1_q;
  logic             mode_s1_q, half_s1_q, v_s1_q;
  logic [TAG_W-1:0] tag_s1_q;
  // Stage 2: GS pre-add/sub; u is the non-multiplied operand, x the mult operand
  logic [BW-1:0]    u_s2_q, x_s2_q, rou_s2_q;
  logic             mode_s2_q, half_s2_q, v_s2_q;
  logic [TAG_W-1:0] tag_s2_q;
  // Modular multiplier: product register, Barrett reduction, then pure delay
  logic [2*BW-1:0]  prod_q;
  logic [BW-1:0]    res_q [1:ML-1];
  // Sideband delay matched to the multiplier
  logic [BW-1:0]    u_q   [0:ML-1];
  logic [TAG_W-1:0] tag_q [0:ML-1];
  logic [ML-1:0]    mode_q, half_q, v_q;

  // Barrett: qhat = (c*m) >> k2 never overshoots, so r < 3q and two
  // conditional subtractions finish the reduction.
  logic [CMW-1:0] cm_w;
  logic [BW+1:0]  r0_w, r_d;
  logic [BW-1:0]  red_d;
  assign cm_w = CMW'(prod_q) * CMW'(m);
  assign r0_w = (BW+2)'(CMW'(prod_q) - (cm_w >> k2) * CMW'(q));

  always_comb begin
    r_d = r0_w;
    if (r_d >= (BW+2)'(q)) r_d = r_d - (BW+2)'(q);
    if (r_d >= (BW+2)'(q)) r_d = r_d - (BW+2)'(q);
    red_d = BW'(r_d);
  end

  // Operand path: no reset, the valid pipeline qualifies everything
  always_ff @(posedge clk) begin
    a_s1_q    <= a;
    b_s1_q    <= b;
    rou_s1_q  <= rou;
    mode_s1_q <= mode;
    half_s1_q <= half_en;
    tag_s1_q  <= in_tag;

    // CT beats just pass a/b through stage 2 so both modes enter the
    // multiplier from the same stage and never collide.
    u_s2_q    <= mode_s1_q ? add_mod(a_s1_q, b_s1_q, q) : a_s1_q;
    x_s2_q    <= mode_s1_q ? sub_mod(a_s1_q, b_s1_q, q) : b_s1_q;
    rou_s2_q  <= rou_s1_q;
    mode_s2_q <= mode_s1_q;
    half_s2_q <= half_s1_q;
    tag_s2_q  <= tag_s1_q;

    prod_q   <= (2*BW)'(x_s2_q) * (2*BW)'(rou_s2_q);
    res_q[1] <= red_d;
    for (int i = 2; i < ML; i++) res_q[i] <= res_q[i-1];

    u_q[0]   <= u_s2_q;
    tag_q[0] <= tag_s2_q;
    for (int i = 1; i < ML; i++) begin
      u_q[i]   <= u_q[i-1];
      tag_q[i] <= tag_q[i-1];
    end
    mode_q <= {mode_q[ML-2:0], mode_s2_q};
    half_q <= {half_q[ML-2:0], half_s2_q};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_s1_q <= 1'b0;
      v_s2_q <= 1'b0;
      v_q    <= '0;
    end else begin
      v_s1_q <= in_valid;
      v_s2_q <= v_s1_q;
      v_q    <= {v_q[ML-2:0], v_s2_q};
    end
  end

  // Final add/sub (CT) or optional halving (GS)
  logic [BW-1:0] p_w, u_w, outa_d, outb_d;
  logic          gs_w, hv_w;
  assign p_w  = res_q[ML-1];
  assign u_w  = u_q[ML-1];
  assign gs_w = mode_q[ML-1];
  assign hv_w = gs_w & half_q[ML-1];

  always_comb begin
    outa_d = add_mod(u_w, p_w, q);
    outb_d = sub_mod(u_w, p_w, q);
    if (gs_w) begin
      outa_d = hv_w ? halve(u_w, q) : u_w;
      outb_d = hv_w ? halve(p_w, q) : p_w;
    end
  end

  // Outputs only move on valid beats and hold across bubbles
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      outa      <= '0;
      outb      <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= v_q[ML-1];
      if (v_q[ML-1]) begin
        outa    <= outa_d;
        outb    <= outb_d;
        out_tag <= tag_q[ML-1];
      end
    end
  end

  assign busy = v_s1_q | v_s2_q | (|v_q);

endmodule
